irq_pending_latch: RTL and testbench
====================================

# irq_pending_latch

- Captures rising edges on eight asynchronous request lines into sticky pending bits.
- Presents the unmasked pending vector to the 8-to-3 priority encoder through `data`.
- Raises `irq` while any unmasked request is pending.
- When the consumer acknowledges, clears the pending bit the encoder selected; the consumer returns the encoder's `out` as `ack_id`.
- Sits directly upstream of the priority encoder in the interrupt path.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth per request line. Legal values are 2 and 3.

Ports:
- `clk` — input, 1 bit: single clock; all state updates on the rising edge.
- `rst` — input, 1 bit: asynchronous, active-high reset.
- `req` — input, 8 bits: asynchronous request lines; a rising edge on bit i is a request.
- `mask` — input, 8 bits: synchronous; 1 masks bit i from `data` and `irq`. Does not block capture.
- `ack` — input, 1 bit: consumer accepts the current request.
- `ack_id` — input, 3 bits: index to clear, driven from the encoder's `out`.
- `data` — output, 8 bits: `pending & ~mask`. Combinational from the `pending` register and `mask`; feeds the encoder's `data` input.
- `pending` — output, 8 bits: raw sticky pending register.
- `irq` — output, 1 bit: registered interrupt request.
- `state` — output, 2 bits: FSM state for debug.

## Operation

Request path, per bit:
- `req[i]` passes through `SYNC_STAGES` flops, then one previous-value flop.
- An edge is detected when the synchroniser output is 1 and the previous value is 0.
- An edge sets `pending[i]`.

FSM state encodings and transitions:
- IDLE = 0: stay while `data` == 0; go to REQ when `data` != 0.
- REQ = 1: `irq` = 1.
  - On `ack`: clear `pending[ack_id]` and go to HOLD.
  - If `data` becomes 0 without `ack` (masking): go to IDLE.
- HOLD = 2: one blanking cycle so the encoder settles on the updated `data`. Next state is REQ if `data` != 0, else IDLE.
- Encoding 3 is unused and recovers to IDLE.

Boundary rules:
- `ack` in IDLE or HOLD is ignored; no bit is cleared.
- `ack_id` naming a bit that is not pending: no register change; the FSM still goes to HOLD.
- Set and clear of the same bit in the same cycle: the set wins, so the new event is not lost.
- An edge on a bit that is already pending is absorbed; see Configuration.
- `mask` never modifies `pending`; unmasking a pending bit re-raises `irq`.
- Multiple edges in one cycle all set their bits.

Reset:
- Asynchronous assertion clears synchronisers, previous-value flops and `pending`, sets FSM to IDLE, and drives `irq` = 0 and `data` = 0 immediately.
- Reset mid-operation, including during REQ or HOLD, drops all pending requests.
- After release, a `req` bit that is already high is seen as a rising edge, because the previous-value flop resets to 0.

## Timing

- A `req[i]` rise that meets setup before edge k gives `pending[i]` = 1 after edge k+`SYNC_STAGES` (latency `SYNC_STAGES`+1 edges).
- `data` follows `pending` and `mask` in the same cycle.
- `irq` rises one edge after `data` becomes non-zero (IDLE→REQ).
- `ack` sampled at edge n: the bit clears and `irq` falls after edge n, giving one low cycle (HOLD).
- If other requests remain, `irq` rises again after edge n+1.
- Minimum spacing between served interrupts: 2 cycles.
- A `req` pulse shorter than one clock period may be missed. Requests must be held at least 2 clock periods high and 2 low.

## Configuration

- `IRQ_OVERFLOW_EN` defined:
  - Adds output `overflow` (8 bits).
  - `overflow[i]` is sticky; it is set when an edge on bit i arrives while `pending[i]` is already 1 and is not being cleared that cycle.
  - Cleared only by `rst`; reset value 0.
- `IRQ_OVERFLOW_EN` undefined: no `overflow` port and no overflow logic; repeat edges are silently absorbed.

## Test plan

- Reset then idle: `rst` = 1 with `req` = 8'h00 → `pending` = 0, `data` = 0, `irq` = 0, `state` = 0; still 0 twenty cycles after release.
- Single request with `SYNC_STAGES` = 2: raise `req[3]`, `mask` = 0 → `pending` = 8'h08 after 3 edges, `irq` = 1 one edge later; `ack` = 1 with `ack_id` = 3 → `pending` = 0, `irq` = 0, `state` goes HOLD then IDLE.
- Two requests: `req` = 8'h81 → `data` = 8'h81; `ack_id` = 7 clears bit 7, `irq` is low for exactly one cycle then high with `data` = 8'h01; `ack_id` = 0 → `irq` = 0.
- Masking: `pending` = 8'h10 with `mask` = 8'h10 → `data` = 0, `irq` = 0, `pending` still 8'h10; clearing `mask` → `irq` = 1 one edge later.
- Collision: an edge on bit 2 in the same cycle as `ack` with `ack_id` = 2 → `pending[2]` stays 1; `ack` asserted while in IDLE → no change.
- Reset mid-request: assert `rst` in REQ with `pending` = 8'h24 → `irq` = 0 and `pending` = 0 before the next edge. With `IRQ_OVERFLOW_EN` defined, a second `req[5]` edge while `pending[5]` is set → `overflow` = 8'h20.

Source files
------------

// File: rtl/irq_pending_latch.sv
// Synchronises eight asynchronous request lines, latches their rising edges into sticky
// pending bits and hands them to a priority encoder. Optional macro: IRQ_OVERFLOW_EN.
module irq_pending_latch #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic [7:0] mask,
   input  logic       ack,
   input  logic [2:0] ack_id,
   output logic [7:0] data,
   output logic [7:0] pending,
   output logic       irq,
   output logic [1:0] state
`ifdef IRQ_OVERFLOW_EN
   ,
   output logic [7:0] overflow
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t     cur_state;
   state_t     nxt_state;
   logic [7:0] sync_q [SYNC_STAGES];
   logic [7:0] prev_q;
   logic [7:0] pending_q;
   logic [7:0] rise;
   logic [7:0] clr;

   // Previous-value flop resets to 0, so a line already high at release counts as an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
         prev_q <= '0;
      end else begin
         sync_q[0] <= req;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

   always_comb begin
      clr = '0;
      if (cur_state == REQ && ack) begin
         clr[ack_id] = 1'b1;
      end
   end

   // Set is OR-ed after the clear so a fresh edge on the acknowledged bit survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= (pending_q & ~clr) | rise;
      end
   end

`ifdef IRQ_OVERFLOW_EN
   logic [7:0] overflow_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q <= '0;
      end else begin
         overflow_q <= overflow_q | (rise & pending_q & ~clr);
      end
   end

   assign overflow = overflow_q;
`endif

   assign pending = pending_q;
   assign data    = pending_q & ~mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // HOLD gives the encoder one cycle to settle on the updated data before irq returns.
   always_comb begin
      nxt_state = IDLE;
      case (cur_state)
         IDLE: begin
            nxt_state = (data != 8'h00) ? REQ : IDLE;
         end
         REQ: begin
            if (ack) begin
               nxt_state = HOLD;
            end else if (data == 8'h00) begin
               nxt_state = IDLE;
            end else begin
               nxt_state = REQ;
            end
         end
         HOLD: begin
            nxt_state = (data != 8'h00) ? REQ : IDLE;
         end
         default: begin
            nxt_state = IDLE;
         end
      endcase
   end

   assign irq   = (cur_state == REQ);
   assign state = cur_state;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch: stimulus pushes hand-computed expectations into a
// scoreboard that a negedge monitor drains and compares.
module tb_irq_pending_latch;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic [7:0] mask = 8'h00;
   logic       ack = 1'b0;
   logic [2:0] ack_id = 3'd0;
   logic [7:0] data;
   logic [7:0] pending;
   logic       irq;
   logic [1:0] state;
`ifdef IRQ_OVERFLOW_EN
   logic [7:0] overflow;
`endif

   irq_pending_latch #(.SYNC_STAGES(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .mask    (mask),
      .ack     (ack),
      .ack_id  (ack_id),
      .data    (data),
      .pending (pending),
      .irq     (irq),
      .state   (state)
`ifdef IRQ_OVERFLOW_EN
      ,
      .overflow(overflow)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [7:0] p;
      logic [7:0] d;
      logic [7:0] o;
      logic       i;
      logic [1:0] s;
   } exp_t;

   exp_t       sb[$];
   string      nm_q[$];
   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] exp_ovf = 8'h00;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input string nm, input logic [7:0] p, input logic [7:0] d,
                           input logic i, input logic [1:0] s);
      exp_t e;
      e.cyc = cyc;
      e.p   = p;
      e.d   = d;
      e.o   = exp_ovf;
      e.i   = i;
      e.s   = s;
      sb.push_back(e);
      nm_q.push_back(nm);
   endtask

   task automatic cmp(input string nm, input string fld, input logic [7:0] act,
                      input logic [7:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s.%s: got %h, expected %h (cycle %0d)", nm, fld, act, want, cyc);
      end
   endtask

   // Monitor: checks every expectation queued for the current cycle.
   always @(negedge clk) begin
      exp_t  e;
      string nm;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e  = sb.pop_front();
         nm = nm_q.pop_front();
         if (e.cyc != cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: entry for cycle %0d reached monitor at cycle %0d", nm, e.cyc, cyc);
         end else begin
            cmp(nm, "pending", pending, e.p);
            cmp(nm, "data", data, e.d);
            cmp(nm, "irq", {7'b0, irq}, {7'b0, e.i});
            cmp(nm, "state", {6'b0, state}, {6'b0, e.s});
`ifdef IRQ_OVERFLOW_EN
            cmp(nm, "overflow", overflow, e.o);
`endif
         end
      end
   end

   initial begin
      // Reset then idle
      step(3);
      push_exp("reset", 8'h00, 8'h00, 1'b0, 2'd0);
      rst = 1'b0;
      step(20);
      push_exp("idle20", 8'h00, 8'h00, 1'b0, 2'd0);

      // Single request on bit 3
      req = 8'h08;
      step(2);
      push_exp("single_sync", 8'h00, 8'h00, 1'b0, 2'd0);
      step(1);
      push_exp("single_pend", 8'h08, 8'h08, 1'b0, 2'd0);
      step(1);
      push_exp("single_irq", 8'h08, 8'h08, 1'b1, 2'd1);
      ack = 1'b1; ack_id = 3'd3;
      step(1);
      push_exp("single_hold", 8'h00, 8'h00, 1'b0, 2'd2);
      ack = 1'b0;
      step(1);
      push_exp("single_idle", 8'h00, 8'h00, 1'b0, 2'd0);
      req = 8'h00;
      step(3);

      // Two simultaneous requests
      req = 8'h81;
      step(3);
      push_exp("two_pend", 8'h81, 8'h81, 1'b0, 2'd0);
      step(1);
      push_exp("two_irq", 8'h81, 8'h81, 1'b1, 2'd1);
      ack = 1'b1; ack_id = 3'd7;
      step(1);
      push_exp("two_hold", 8'h01, 8'h01, 1'b0, 2'd2);
      ack = 1'b0;
      step(1);
      push_exp("two_reirq", 8'h01, 8'h01, 1'b1, 2'd1);
      ack = 1'b1; ack_id = 3'd0;
      step(1);
      push_exp("two_hold2", 8'h00, 8'h00, 1'b0, 2'd2);
      ack = 1'b0;
      step(1);
      push_exp("two_idle", 8'h00, 8'h00, 1'b0, 2'd0);
      req = 8'h00;
      step(3);

      // Masking holds the bit pending without irq; unmasking raises irq
      mask = 8'h10; req = 8'h10;
      step(3);
      push_exp("mask_pend", 8'h10, 8'h00, 1'b0, 2'd0);
      step(2);
      mask = 8'h00;
      push_exp("unmask_data", 8'h10, 8'h10, 1'b0, 2'd0);
      step(1);
      push_exp("unmask_irq", 8'h10, 8'h10, 1'b1, 2'd1);
      ack = 1'b1; ack_id = 3'd4;
      step(1);
      push_exp("mask_clr", 8'h00, 8'h00, 1'b0, 2'd2);
      ack = 1'b0; req = 8'h00;
      step(1);
      push_exp("mask_idle", 8'h00, 8'h00, 1'b0, 2'd0);
      step(2);

      // Collision: new edge on bit 2 lands on the cycle its ack is sampled
      req = 8'h04;
      step(3);
      push_exp("coll_pend", 8'h04, 8'h04, 1'b0, 2'd0);
      step(1);
      push_exp("coll_req", 8'h04, 8'h04, 1'b1, 2'd1);
      req = 8'h00;
      step(3);
      req = 8'h04;
      step(2);
      ack = 1'b1; ack_id = 3'd2;
      step(1);
      push_exp("coll_setwins", 8'h04, 8'h04, 1'b0, 2'd2);
      ack = 1'b0;
      step(1);
      push_exp("coll_reirq", 8'h04, 8'h04, 1'b1, 2'd1);
      ack = 1'b1; ack_id = 3'd2;
      step(1);
      push_exp("coll_clr", 8'h00, 8'h00, 1'b0, 2'd2);
      ack = 1'b0; req = 8'h00;
      step(3);

      // Ack in IDLE ignored; ack of a non-pending id still goes to HOLD
      mask = 8'h02; req = 8'h02;
      step(3);
      push_exp("idle_pend", 8'h02, 8'h00, 1'b0, 2'd0);
      ack = 1'b1; ack_id = 3'd1;
      step(1);
      push_exp("idle_ack", 8'h02, 8'h00, 1'b0, 2'd0);
      ack = 1'b0;
      step(1);
      mask = 8'h00;
      push_exp("idle_unmask", 8'h02, 8'h02, 1'b0, 2'd0);
      step(1);
      push_exp("badid_req", 8'h02, 8'h02, 1'b1, 2'd1);
      ack = 1'b1; ack_id = 3'd5;
      step(1);
      push_exp("badid_hold", 8'h02, 8'h02, 1'b0, 2'd2);
      ack = 1'b0;
      step(1);
      push_exp("badid_reirq", 8'h02, 8'h02, 1'b1, 2'd1);
      ack = 1'b1; ack_id = 3'd1;
      step(1);
      push_exp("badid_clr", 8'h00, 8'h00, 1'b0, 2'd2);
      ack = 1'b0; req = 8'h00;
      step(1);
      push_exp("badid_idle", 8'h00, 8'h00, 1'b0, 2'd0);
      step(2);

      // Asynchronous reset while in REQ
      req = 8'h24;
      step(3);
      push_exp("rst_pend", 8'h24, 8'h24, 1'b0, 2'd0);
      step(1);
      push_exp("rst_req", 8'h24, 8'h24, 1'b1, 2'd1);
      step(1);
      #1 rst = 1'b1;
      #1 push_exp("rst_async", 8'h00, 8'h00, 1'b0, 2'd0);
      step(1);
      rst = 1'b0;
      push_exp("rst_release", 8'h00, 8'h00, 1'b0, 2'd0);
      // Lines still high after release are captured as fresh edges
      step(3);
      push_exp("rst_recap", 8'h24, 8'h24, 1'b0, 2'd0);
      step(1);
      push_exp("rst_reirq", 8'h24, 8'h24, 1'b1, 2'd1);
      req = 8'h04;
      step(3);
      req = 8'h24;
      step(3);
`ifdef IRQ_OVERFLOW_EN
      exp_ovf = 8'h20;
`endif
      push_exp("repeat_edge", 8'h24, 8'h24, 1'b1, 2'd1);
      ack = 1'b1; ack_id = 3'd5;
      step(1);
      push_exp("rep_clr5", 8'h04, 8'h04, 1'b0, 2'd2);
      ack = 1'b0;
      step(1);
      push_exp("rep_reirq", 8'h04, 8'h04, 1'b1, 2'd1);
      ack = 1'b1; ack_id = 3'd2;
      step(1);
      push_exp("rep_clr2", 8'h00, 8'h00, 1'b0, 2'd2);
      ack = 1'b0; req = 8'h00;
      step(1);
      push_exp("rep_idle", 8'h00, 8'h00, 1'b0, 2'd0);

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
